ss_rr_arbiter_n: RTL and testbench



---
 rtl/ss_arb_pkg.sv | 27 ++
 rtl/ss_rr_pick.sv | 40 ++++
 rtl/ss_rr_arbiter_n.sv | 134 +++++++++++++
 tb/tb_ss_rr_arbiter_n.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ss_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ss_arb_pkg
//  Description : Shared types, constants and helpers for the simple-stream
//                round-robin arbiter.
//                  arb_state_t : arbiter state (idle search / packet lock)
//                  PKT_CNT_W   : width of the per-source packet counters
//                  rr_next()   : round-robin pointer increment with wrap
//  Revision    : 1.0 - initial release
// ============================================================================
package ss_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    localparam int PKT_CNT_W = 16;

    // Next search start after a grant at ptr: ptr+1, wrapping to 0 at n.
    function automatic int unsigned rr_next(input int unsigned ptr,
                                            input int unsigned n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ss_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : ss_rr_pick
//  Description : Combinational round-robin find-first. Scans the request
//                vector starting at i_ptr, wrapping modulo N, and returns the
//                first requesting index.
//  Ports       : i_req     [N-1:0]  request vector
//                i_ptr     [W-1:0]  index where the search starts (< N)
//                o_gnt_idx [W-1:0]  winning index (0 when nothing requests)
//                o_gnt_any          at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module ss_rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [W-1:0] o_gnt_idx,
    output logic         o_gnt_any
);

    // Walk offsets from the farthest back to the pointer itself so that the
    // smallest rotated offset is the one left standing.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        o_gnt_idx = '0;
        o_gnt_any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (32'(i_ptr) + 32'(k)) % 32'(N);
            if (i_req[idx]) begin
                o_gnt_idx = W'(idx);
                o_gnt_any = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ss_rr_arbiter_n.sv
`default_nettype none
// ============================================================================
//  Module      : ss_rr_arbiter_n
//  Description : Packet-aware round-robin arbiter for NUM_SRC valid/ready/
//                data/last streams feeding one registered output stage.
//                A grant is held from the first beat of a packet until its
//                last beat is accepted; the pointer then moves past the
//                granted source.
//  Ports       : clk, rst_n (async, active-low)
//                in_valid/in_ready/in_last [NUM_SRC], in_data [NUM_SRC]x[DATA_W]
//                out_valid/out_ready/out_data/out_last, out_src [SRC_W]
//                pkt_cnt [NUM_SRC]x[16] (only with SS_RR_ARBITER_PKT_CNT_EN)
//  Options     : SS_RR_ARBITER_PKT_CNT_EN - per-source saturating counters of
//                accepted last beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module ss_rr_arbiter_n
    import ss_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_SRC-1:0]       in_valid,
    output logic [NUM_SRC-1:0]       in_ready,
    input  logic [DATA_W-1:0]        in_data [NUM_SRC],
    input  logic [NUM_SRC-1:0]       in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic [$clog2(NUM_SRC)-1:0] out_src
`ifdef SS_RR_ARBITER_PKT_CNT_EN
    ,
    output logic [PKT_CNT_W-1:0]     pkt_cnt [NUM_SRC]
`endif
);

    localparam int SRC_W = $clog2(NUM_SRC);

    arb_state_t          r_state;
    logic [SRC_W-1:0]    r_lock;
    logic [SRC_W-1:0]    r_ptr;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_last;
    logic [SRC_W-1:0]    r_out_src;

    logic                w_can_load;
    logic [SRC_W-1:0]    w_pick_idx;
    logic                w_pick_any;
    logic [SRC_W-1:0]    w_gnt_idx;
    logic                w_gnt_en;
    logic                w_accept;
    logic [NUM_SRC-1:0]  w_in_ready;

    ss_rr_pick #(
        .N (NUM_SRC),
        .W (SRC_W)
    ) u_pick (
        .i_req     (in_valid),
        .i_ptr     (r_ptr),
        .o_gnt_idx (w_pick_idx),
        .o_gnt_any (w_pick_any)
    );

    assign w_can_load = !r_out_valid || out_ready;

    // While locked the owner keeps the grant even when it bubbles.
    assign w_gnt_idx = (r_state == ARB_LOCKED) ? r_lock : w_pick_idx;
    assign w_gnt_en  = (r_state == ARB_LOCKED) ? 1'b1   : w_pick_any;

    // Ready is held low throughout reset so nothing is taken while the
    // surrounding logic is also being reset.
    always_comb begin
        w_in_ready = '0;
        if (rst_n && w_gnt_en) begin
            w_in_ready[w_gnt_idx] = w_can_load;
        end
    end

    assign in_ready = w_in_ready;
    assign w_accept = w_gnt_en && in_valid[w_gnt_idx] && w_can_load && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ARB_IDLE;
            r_lock      <= '0;
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_src   <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data[w_gnt_idx];
            r_out_last  <= in_last[w_gnt_idx];
            r_out_src   <= w_gnt_idx;
            if (in_last[w_gnt_idx]) begin
                r_state <= ARB_IDLE;
                r_ptr   <= SRC_W'(rr_next(32'(w_gnt_idx), NUM_SRC));
            end else begin
                r_state <= ARB_LOCKED;
                r_lock  <= w_gnt_idx;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_src   = r_out_src;

`ifdef SS_RR_ARBITER_PKT_CNT_EN
    logic [PKT_CNT_W-1:0] r_pkt_cnt [NUM_SRC];

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_pkt_cnt
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_pkt_cnt[gi] <= '0;
            end else if (w_accept && (w_gnt_idx == SRC_W'(gi)) && in_last[gi]
                         && (r_pkt_cnt[gi] != {PKT_CNT_W{1'b1}})) begin
                r_pkt_cnt[gi] <= r_pkt_cnt[gi] + 1'b1;
            end
        end
        assign pkt_cnt[gi] = r_pkt_cnt[gi];
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ss_rr_arbiter_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ss_rr_arbiter_n
//  Description : Self-checking bench for ss_rr_arbiter_n (NUM_SRC=4,
//                DATA_W=32). Directed scenarios followed by random traffic,
//                all compared against a packet-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ss_rr_arbiter_n;

    localparam int NSRC = 4;
    localparam int DW   = 32;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic [NSRC-1:0] in_valid;
    logic [NSRC-1:0] in_ready;
    logic [NSRC-1:0] in_last;
    logic [DW-1:0]   in_data [NSRC];
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic [1:0]      out_src;
`ifdef SS_RR_ARBITER_PKT_CNT_EN
    logic [15:0]     pkt_cnt [NSRC];
`endif

    always #5 clk = ~clk;

    ss_rr_arbiter_n #(
        .NUM_SRC (NSRC),
        .DATA_W  (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src)
`ifdef SS_RR_ARBITER_PKT_CNT_EN
        ,
        .pkt_cnt   (pkt_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who owns the path, where the next search starts,
    // and what the output register should hold.
    int          m_ptr;
    bit          m_locked;
    int          m_owner;
    bit          m_ov;
    bit          m_ol;
    logic [DW-1:0] m_od;
    int          m_os;
    int          m_cnt [NSRC];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_ptr = 0; m_locked = 0; m_owner = 0;
        m_ov = 0; m_ol = 0; m_od = '0; m_os = 0;
        for (int i = 0; i < NSRC; i++) m_cnt[i] = 0;
    endtask

    // Owner of the path this cycle, or -1 if nobody may send.
    function automatic int m_winner();
        if (m_locked) return m_owner;
        for (int k = 0; k < NSRC; k++)
            if (in_valid[(m_ptr + k) % NSRC]) return (m_ptr + k) % NSRC;
        return -1;
    endfunction

    // One clock: check ready before the edge, advance the model, check the
    // registered outputs just after the edge.
    task automatic step();
        int            w;
        bit            can;
        bit            acc;
        logic [NSRC-1:0] er;
        logic [DW-1:0] d;
        bit            l;
        #1;
        w   = m_winner();
        can = !m_ov || out_ready;
        er  = '0;
        if (w >= 0 && can) er[w] = 1'b1;
        chk("in_ready", 64'(in_ready), 64'(er));
        acc = (w >= 0) && in_valid[w] && can;
        d = '0; l = 0;
        if (w >= 0) begin d = in_data[w]; l = in_last[w]; end
        @(posedge clk);
        if (acc) begin
            m_ov = 1; m_od = d; m_ol = l; m_os = w;
            if (l) begin
                m_locked = 0;
                m_ptr    = (w + 1) % NSRC;
                if (m_cnt[w] < 65535) m_cnt[w]++;
            end else begin
                m_locked = 1;
                m_owner  = w;
            end
        end else if (out_ready) begin
            m_ov = 0;
        end
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        chk("out_data",  64'(out_data),  64'(m_od));
        chk("out_last",  64'(out_last),  64'(m_ol));
        chk("out_src",   64'(out_src),   64'(m_os));
`ifdef SS_RR_ARBITER_PKT_CNT_EN
        for (int i = 0; i < NSRC; i++) chk("pkt_cnt", 64'(pkt_cnt[i]), 64'(m_cnt[i]));
`endif
    endtask

    initial begin
        in_valid  = '0;
        in_last   = '0;
        out_ready = 1'b0;
        for (int i = 0; i < NSRC; i++) in_data[i] = 32'h1000_0000 * (i + 1);

        // ---- Reset with every source requesting ----
        in_valid = 4'b1111;
        rst_n    = 1'b0;
        #1;
        m_reset();
        chk("rst_in_ready",  64'(in_ready),  64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_data",  64'(out_data),  64'h0);
        chk("rst_out_src",   64'(out_src),   64'h0);
        chk("rst_out_last",  64'(out_last),  64'h0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // ---- Fairness: single-beat packets, all valid ----
        in_last   = 4'b1111;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < NSRC; i++) in_data[i] = 32'(c * 16 + i);
            step();
            chk("fair_src",   64'(out_src),   64'(c % 4));
            chk("fair_valid", 64'(out_valid), 64'h1);
        end

        // Move the pointer to 2 with one beat from source 1.
        in_valid = 4'b0010;
        step();

        // ---- Packet lock: source 2 sends three beats, 0 and 3 waiting ----
        in_valid = 4'b1101;
        for (int b = 0; b < 3; b++) begin
            in_last = (b == 2) ? 4'b1101 : 4'b1001;
            in_data[2] = 32'hA000_0000 + 32'(b);
            step();
            chk("lock_src", 64'(out_src), 64'h2);
        end
        in_valid = 4'b1001;
        step();
        chk("lock_then3", 64'(out_src), 64'h3);
        step();
        chk("lock_then0", 64'(out_src), 64'h0);

        // ---- Backpressure holding DEADBEEF ----
        in_valid   = 4'b0001;
        in_last    = 4'b1111;
        in_data[0] = 32'hDEADBEEF;
        step();
        chk("bp_load", 64'(out_data), 64'hDEADBEEF);
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            in_data[0] = 32'(c);
            step();
            chk("bp_hold_data",  64'(out_data),  64'hDEADBEEF);
            chk("bp_hold_valid", 64'(out_valid), 64'h1);
            chk("bp_ready_low",  64'(in_ready),  64'h0);
        end
        out_ready  = 1'b1;
        in_data[1] = 32'h1111_2222;
        step();
        chk("bp_reload_src",  64'(out_src),  64'h1);
        chk("bp_reload_data", 64'(out_data), 64'h1111_2222);

        // ---- Reset in the middle of a packet from source 1 ----
        in_valid = 4'b0010;
        in_last  = 4'b0000;
        step();
        step();
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("mid_rst_valid", 64'(out_valid), 64'h0);
        chk("mid_rst_ready", 64'(in_ready),  64'h0);
        @(posedge clk); #1;
        rst_n      = 1'b1;
        in_valid   = 4'b1000;
        in_last    = 4'b1000;
        in_data[3] = 32'h3333_3333;
        step();
        chk("post_rst_src3", 64'(out_src),   64'h3);
        chk("post_rst_vld",  64'(out_valid), 64'h1);

        // ---- Random traffic against the model ----
        for (int c = 0; c < 400; c++) begin
            in_valid  = 4'($urandom);
            for (int i = 0; i < NSRC; i++) begin
                in_last[i] = ($urandom_range(0, 2) != 0);
                in_data[i] = $urandom;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

`ifdef SS_RR_ARBITER_PKT_CNT_EN
        // ---- Packet counters and saturation ----
        rst_n = 1'b0;
        #1;
        m_reset();
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_last   = 4'b1111;
        in_valid  = 4'b0001;
        for (int c = 0; c < 5; c++) step();
        in_valid = 4'b0010;
        for (int c = 0; c < 3; c++) step();
        chk("cnt0_5", 64'(pkt_cnt[0]), 64'd5);
        chk("cnt1_3", 64'(pkt_cnt[1]), 64'd3);
        in_valid = 4'b0001;
        for (int c = 0; c < 65535; c++) step();
        chk("cnt0_sat", 64'(pkt_cnt[0]), 64'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
